// File: rtl/dotp_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dotp_mult_ctrl_if
//  Purpose  : Bundles the operand handshake, the multiplier launch/return
//             signals and the result outputs of dotp_mult_ctrl.
//  Modports : slave  - controller view (operands in, results out)
//             master - surrounding logic view (operands out, results in)
//  Signals  : Clear, In_valid, In_ready, A[7:0], B[7:0],
//             Mult_start, Mult_mplier[7:0], Mult_mcand[7:0],
//             Mult_finish, Mult_product[17:0],
//             Acc_out[ACC_W-1:0], Done, Overflow
//  Revision : 1.0 - initial release
// ============================================================================
interface dotp_mult_ctrl_if #(
    parameter int ACC_W = 20
);
    logic             Clear;
    logic             In_valid;
    logic             In_ready;
    logic [7:0]       A;
    logic [7:0]       B;
    logic             Mult_start;
    logic [7:0]       Mult_mplier;
    logic [7:0]       Mult_mcand;
    logic             Mult_finish;
    logic [17:0]      Mult_product;
    logic [ACC_W-1:0] Acc_out;
    logic             Done;
    logic             Overflow;

    modport slave (
        input  Clear, In_valid, A, B, Mult_finish, Mult_product,
        output In_ready, Mult_start, Mult_mplier, Mult_mcand,
               Acc_out, Done, Overflow
    );

    modport master (
        output Clear, In_valid, A, B, Mult_finish, Mult_product,
        input  In_ready, Mult_start, Mult_mplier, Mult_mcand,
               Acc_out, Done, Overflow
    );
endinterface
`default_nettype wire

// File: rtl/dotp_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dotp_mult_ctrl
//  Purpose  : Dot-product sequencer around an 8x8 signed sequential
//             multiplier. Accepts operand pairs, launches one multiply per
//             pair, accumulates Product[16:1] into a signed accumulator and
//             pulses Done after N_TERMS products.
//  Ports    : clk    - clock, rising edge
//             Resetn - synchronous active-low reset
//             bus    - dotp_mult_ctrl_if.slave (handshake, multiplier link,
//                      accumulator, Done, Overflow, Clear)
//  Params   : N_TERMS - operand pairs per dot product (>= 1)
//             ACC_W   - signed accumulator width (>= 16)
//  Options  : DOTP_SATURATE_EN - when defined the accumulator saturates on
//             signed overflow; otherwise it wraps (Overflow set either way)
//  Revision : 1.0 - initial release
// ============================================================================
module dotp_mult_ctrl #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 20
) (
    input  wire logic         clk,
    input  wire logic         Resetn,
    dotp_mult_ctrl_if.slave   bus
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_WAIT  = 3'd3,
        S_ACCUM = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [ACC_W-1:0] term_q,      term_d;
    logic             ovf_q,       ovf_d;
    logic             done_q,      done_d;
    logic [7:0]       mplier_q,    mplier_d;
    logic [7:0]       mcand_q,     mcand_d;
    // DRAIN has to see Finish low before a high Finish marks the end of the
    // abandoned multiply; this remembers that the low phase was observed.
    logic             drain_low_q, drain_low_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W:0]   acc_sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_next;

    // Product bit 17 is a redundant sign and bit 0 is the multiplier's
    // shift guard bit; only [16:1] carries the result.
    logic             unused_product_bits;
    assign unused_product_bits = bus.Mult_product[17] ^ bus.Mult_product[0];

    // One extra bit holds the true sum; overflow is a disagreement between
    // the top two bits.
    assign acc_sum = {acc_q[ACC_W-1], acc_q} + {term_q[ACC_W-1], term_q};
    assign sum_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];

`ifdef DOTP_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The extra top bit gives the sign of the true result.
    assign acc_next = !sum_ovf       ? acc_sum[ACC_W-1:0] :
                      acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
`else
    assign acc_next = acc_sum[ACC_W-1:0];
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = (state_q == S_IDLE) && bus.In_valid && !bus.Clear;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        term_d      = term_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        drain_low_d = drain_low_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mplier_d = bus.A;
                    mcand_d  = bus.B;
                    state_d  = S_ISSUE;
                    // First pair of a new dot product starts from zero.
                    if (cnt_q == '0) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            S_ISSUE: state_d = S_ACK;
            S_ACK: begin
                // A Finish still high here belongs to the previous multiply.
                if (!bus.Mult_finish) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.Mult_finish) begin
                    term_d  = ACC_W'($signed(bus.Mult_product[16:1]));
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d   = acc_next;
                ovf_d   = ovf_q | sum_ovf;
                state_d = S_IDLE;
                if (cnt_inc == LAST_CNT) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                end
            end
            S_DRAIN: begin
                if (!drain_low_q) begin
                    if (!bus.Mult_finish) begin
                        drain_low_d = 1'b1;
                    end
                end else if (bus.Mult_finish) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides the normal sequencing. A multiply already launched
        // must still run to completion, so those states go through DRAIN.
        if (bus.Clear) begin
            acc_d  = '0;
            ovf_d  = 1'b0;
            cnt_d  = '0;
            done_d = 1'b0;
            case (state_q)
                S_ISSUE, S_ACK: begin
                    state_d     = S_DRAIN;
                    drain_low_d = 1'b0;
                end
                S_WAIT: begin
                    // Finish has already been seen low on the way into WAIT.
                    state_d     = S_DRAIN;
                    drain_low_d = 1'b1;
                end
                S_DRAIN: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            term_q      <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            drain_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            term_q      <= term_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            drain_low_q <= drain_low_d;
        end
    end

    // In_ready is withheld while reset or Clear is active so that it never
    // advertises an accept that would be refused.
    assign bus.In_ready    = (state_q == S_IDLE) && Resetn && !bus.Clear;
    assign bus.Mult_start  = (state_q == S_ISSUE);
    assign bus.Mult_mplier = mplier_q;
    assign bus.Mult_mcand  = mcand_q;
    assign bus.Acc_out     = acc_q;
    assign bus.Done        = done_q;
    assign bus.Overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dotp_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dotp_mult_ctrl
//  Purpose  : Self-checking bench for dotp_mult_ctrl. Three instances run in
//             lockstep from one stimulus: N_TERMS=4/ACC_W=20,
//             N_TERMS=4/ACC_W=16 and N_TERMS=1/ACC_W=20, sharing one
//             behavioural sequential-multiplier model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dotp_mult_ctrl;

    localparam int LAT = 6;

    typedef struct {
        longint a20;
        bit     o20;
        longint a16;
        bit     o16;
        longint a1;
        bit     d4;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic        in_valid;
    logic [7:0]  a_in;
    logic [7:0]  b_in;

    logic        m_finish;
    logic [17:0] m_product;
    logic        m_busy;
    logic signed [15:0] m_p;
    int          m_hold;
    int          m_lat;
    int          stale_hold;

    int          n_tests;
    int          n_fail;
    exp_t        sb[$];
    int          cnt4;
    longint      e20, e16;
    bit          eo20, eo16;

    dotp_mult_ctrl_if #(.ACC_W(20)) if20 ();
    dotp_mult_ctrl_if #(.ACC_W(16)) if16 ();
    dotp_mult_ctrl_if #(.ACC_W(20)) if1  ();

    dotp_mult_ctrl #(.N_TERMS(4), .ACC_W(20)) u_dut20 (.clk(clk), .Resetn(resetn), .bus(if20));
    dotp_mult_ctrl #(.N_TERMS(4), .ACC_W(16)) u_dut16 (.clk(clk), .Resetn(resetn), .bus(if16));
    dotp_mult_ctrl #(.N_TERMS(1), .ACC_W(20)) u_dut1  (.clk(clk), .Resetn(resetn), .bus(if1));

    assign if20.Clear = clear;        assign if16.Clear = clear;        assign if1.Clear = clear;
    assign if20.In_valid = in_valid;  assign if16.In_valid = in_valid;  assign if1.In_valid = in_valid;
    assign if20.A = a_in;             assign if16.A = a_in;             assign if1.A = a_in;
    assign if20.B = b_in;             assign if16.B = b_in;             assign if1.B = b_in;
    assign if20.Mult_finish = m_finish;   assign if16.Mult_finish = m_finish;   assign if1.Mult_finish = m_finish;
    assign if20.Mult_product = m_product; assign if16.Mult_product = m_product; assign if1.Mult_product = m_product;

    always #5 clk = ~clk;

    // Sequential multiplier model: Finish optionally stays high for
    // stale_hold cycles after Start, then low for LAT cycles, then high with
    // the product placed in bits [16:1].
    always @(posedge clk) begin
        if (!resetn) begin
            m_finish  <= 1'b0;
            m_product <= '0;
            m_busy    <= 1'b0;
            m_hold    <= 0;
            m_lat     <= 0;
            m_p       <= '0;
        end else if (if20.Mult_start) begin
            m_busy <= 1'b1;
            m_lat  <= LAT;
            m_hold <= stale_hold;
            m_p    <= $signed(if20.Mult_mplier) * $signed(if20.Mult_mcand);
            if (stale_hold == 0) m_finish <= 1'b0;
        end else if (m_busy) begin
            if (m_hold != 0) begin
                m_hold <= m_hold - 1;
                if (m_hold == 1) m_finish <= 1'b0;
            end else if (m_lat > 1) begin
                m_lat <= m_lat - 1;
            end else begin
                m_finish  <= 1'b1;
                m_product <= {m_p[15], m_p, 1'b0};
                m_busy    <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_add(input longint acc, input longint t, input int w,
                                      output longint res, output bit ov);
        longint s, hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        s  = acc + t;
        ov = (s > hi) || (s < lo);
`ifdef DOTP_SATURATE_EN
        res = (s > hi) ? hi : (s < lo) ? lo : s;
`else
        res = s;
        if (s > hi)      res = s - (longint'(1) <<< w);
        else if (s < lo) res = s + (longint'(1) <<< w);
`endif
    endfunction

    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (if20.In_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, ok, 1);
    endtask

    task automatic accept_pair(input logic [7:0] a, input logic [7:0] b);
        wait_ready("ready_before_accept");
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_low_in_issue", if20.In_ready, 0);
        chk("start20_pulse", if20.Mult_start, 1);
        chk("start16_pulse", if16.Mult_start, 1);
        chk("start1_pulse",  if1.Mult_start, 1);
        chk("mplier_captured", if20.Mult_mplier, a);
        chk("mcand_captured",  if20.Mult_mcand, b);
        chk("mplier16_captured", if16.Mult_mplier, a);
        @(negedge clk);
        chk("start_single_cycle", if20.Mult_start, 0);
        chk("ready_low_in_ack", if16.In_ready, 0);
        chk("mplier_stable", if1.Mult_mplier, a);
    endtask

    task automatic push_expect(input logic [7:0] a, input logic [7:0] b);
        longint p;
        bit     ov;
        exp_t   e;
        p = longint'($signed(a)) * longint'($signed(b));
        if (cnt4 == 0) begin
            e20 = 0; eo20 = 1'b0; e16 = 0; eo16 = 1'b0;
        end
        model_add(e20, p, 20, e20, ov); eo20 = eo20 | ov;
        model_add(e16, p, 16, e16, ov); eo16 = eo16 | ov;
        cnt4++;
        e.a20 = e20; e.o20 = eo20; e.a16 = e16; e.o16 = eo16;
        e.a1  = p;
        e.d4  = (cnt4 == 4);
        if (cnt4 == 4) cnt4 = 0;
        sb.push_back(e);
    endtask

    task automatic wait_result();
        exp_t e;
        wait_ready("result_timeout");
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("acc20", $signed(if20.Acc_out), e.a20);
            chk("ovf20", if20.Overflow, e.o20);
            chk("done20", if20.Done, e.d4);
            chk("acc16", $signed(if16.Acc_out), e.a16);
            chk("ovf16", if16.Overflow, e.o16);
            chk("done16", if16.Done, e.d4);
            chk("acc1", $signed(if1.Acc_out), e.a1);
            chk("ovf1", if1.Overflow, 0);
            chk("done1", if1.Done, 1);
            @(negedge clk);
            chk("done_one_cycle", if20.Done | if1.Done, 0);
        end
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        accept_pair(a, b);
        push_expect(a, b);
        wait_result();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  if20.In_ready | if16.In_ready | if1.In_ready, 0);
        chk({tag, "_acc20"},  if20.Acc_out, 0);
        chk({tag, "_acc16"},  if16.Acc_out, 0);
        chk({tag, "_acc1"},   if1.Acc_out, 0);
        chk({tag, "_done"},   if20.Done | if16.Done | if1.Done, 0);
        chk({tag, "_ovf"},    if20.Overflow | if16.Overflow | if1.Overflow, 0);
        chk({tag, "_start"},  if20.Mult_start | if16.Mult_start | if1.Mult_start, 0);
        chk({tag, "_mplier"}, if20.Mult_mplier | if16.Mult_mplier | if1.Mult_mplier, 0);
        chk({tag, "_mcand"},  if20.Mult_mcand | if16.Mult_mcand | if1.Mult_mcand, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cnt4 = 0;
        e20 = 0; e16 = 0; eo20 = 1'b0; eo16 = 1'b0;
        resetn = 1'b0; clear = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; stale_hold = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", if20.In_ready, 1);

        // Dot product: 5202 + 16384 - 16256 - 1 = 5329
        send_pair(8'h66, 8'h33);
        send_pair(8'h80, 8'h80);
        send_pair(8'h7F, 8'h80);
        send_pair(8'hFF, 8'h01);

        // Stale Finish held for 3 cycles after Start on the second term
        send_pair(8'd10, 8'd20);
        stale_hold = 3;
        accept_pair(8'hFB, 8'd7);
        stale_hold = 0;
        @(negedge clk);
        chk("stale_finish_ignored", if20.In_ready, 0);
        push_expect(8'hFB, 8'd7);
        wait_result();
        send_pair(8'd100, 8'd100);
        send_pair(8'h9C, 8'd50);

        // Clear while the third term is in WAIT
        send_pair(8'd50, 8'hFD);
        send_pair(8'd7, 8'd7);
        accept_pair(8'd9, 8'd9);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_acc20", if20.Acc_out, 0);
        chk("clear_acc16", if16.Acc_out, 0);
        chk("clear_ready_low", if20.In_ready, 0);
        chk("clear_no_done", if20.Done | if1.Done, 0);
        wait_ready("drain_timeout");
        chk("drain_waits_finish", m_finish, 1);
        cnt4 = 0;
        send_pair(8'd1, 8'd2);
        send_pair(8'd3, 8'd4);
        send_pair(8'hFB, 8'd6);
        send_pair(8'd127, 8'd127);

        // 4 x (-128 * -128) = 65536: exceeds the 16-bit range
        send_pair(8'h80, 8'h80);
        send_pair(8'h80, 8'h80);
        send_pair(8'h80, 8'h80);
        send_pair(8'h80, 8'h80);

        // Reset while a multiply is in WAIT
        send_pair(8'd33, 8'd44);
        accept_pair(8'd5, 8'd5);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", if20.In_ready, 1);
        chk("no_done_after_midreset", if20.Done | if1.Done, 0);
        cnt4 = 0;
        send_pair(8'hF9, 8'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dotp_mult_ctrl.md
Name: dotp_mult_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 8x8 signed sequential multiplier (multControl).
- Accepts signed operand pairs over a valid/ready handshake, launches each multiply with a one-cycle Start pulse, and waits for Finish.
- Sign-extends Product[16:1] and accumulates it into a wide signed accumulator.
- After N_TERMS products, presents the dot-product result with a one-cycle Done pulse.

Parameters:
N_TERMS, 4, operand pairs per dot product (>=1); the term counter is sized from it.
ACC_W, 20, accumulator width in bits (>=16), signed.

Ports:
clk  in  1  clock; all state updates on rising edge
Resetn  in  1  synchronous, active-low reset
Clear  in  1  synchronous abort/zero of the current dot product
In_valid  in  1  operand pair valid
In_ready  out  1  block can accept a pair
A  in  8  signed multiplier operand
B  in  8  signed multiplicand operand
Mult_start  out  1  one-cycle Start pulse to the multiplier
Mult_mplier  out  8  registered Mplier to the multiplier
Mult_mcand  out  8  registered Mcand to the multiplier
Mult_finish  in  1  multiplier Finish (level)
Mult_product  in  18  multiplier Product; the result is bits [16:1]
Acc_out  out  ACC_W  signed accumulator value
Done  out  1  one-cycle pulse when the N_TERMS-th product has been accumulated
Overflow  out  1  sticky signed-overflow flag for the current dot product

Behaviour:
- Reset (Resetn=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: In_ready=0 for that cycle, Acc_out=0, Done=0, Overflow=0, Mult_start=0, Mult_mplier=0, Mult_mcand=0.
  - Term count goes to 0.
  - Reset mid-operation discards everything. The multiplier shares Resetn.
- States: IDLE, ISSUE, ACK, WAIT, ACCUM, DRAIN.
- IDLE:
  - In_ready=1.
  - On In_valid&In_ready, capture A->Mult_mplier and B->Mult_mcand, then go to ISSUE.
  - If the term count is 0 when a pair is accepted, Acc_out and Overflow are zeroed in the same edge (start of a new dot product).
- ISSUE: Mult_start=1 for exactly this one cycle, then go to ACK.
- ACK:
  - Wait for Mult_finish=0, which shows the multiplier has left its previous finished state.
  - Then go to WAIT.
  - A stale Finish from the prior operation is never taken as a result.
- WAIT: on the first cycle with Mult_finish=1, register the sign-extended Mult_product[16:1] into the term register, then go to ACCUM.
- ACCUM:
  - Acc_out <= Acc_out + term.
  - Increment the term count.
  - If the new count equals N_TERMS: Done=1 for the next cycle only, count <= 0.
  - Always go back to IDLE.
- Latency:
  - Accept edge to Mult_start high: 1 cycle.
  - Mult_finish rising (in WAIT) to Acc_out updated: 2 cycles.
- Operands stay stable on Mult_mplier/Mult_mcand from capture until the next accept.
- Overflow:
  - Set when the true signed sum exceeds the ACC_W-bit range.
  - Sticky until Clear, reset, or the start of a new dot product.
- Clear (takes priority over everything except Resetn):
  - Acc_out=0, Overflow=0, count=0, Done=0.
  - From IDLE or ACCUM: go to IDLE.
  - From ISSUE/ACK/WAIT: go to DRAIN.
- DRAIN:
  - In_ready=0.
  - Wait for Mult_finish=0 then Mult_finish=1 (use the ACK/WAIT sequence internally), discard the product, go to IDLE.
  - Clear asserted while already in DRAIN has no further effect.
- In_valid outside IDLE is ignored; pairs are not queued. In_ready is 0 in every state except IDLE.
- Done and an accept can occur in the same cycle: the accept starts a new dot product (count=0), so Acc_out is zeroed on that edge.

Optional Feature:
- Macro: DOTP_SATURATE_EN.
- Defined: on overflow, Acc_out clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), matching the sign of the true result, and Overflow is set. Later terms add to the clamped value, which is re-clamped as needed.
- Undefined: two's-complement wrap at ACC_W bits; Overflow still set (sticky).

Test Plan:
- Reset then single pair, N_TERMS=1: A=0x66, B=0x33 -> one Mult_start pulse, Mult_mplier=0x66, Mult_mcand=0x33; after Finish, Acc_out=5202 (0x1452), Done pulses 1 cycle, Overflow=0.
- N_TERMS=4, ACC_W=20, pairs (102,51), (-128,-128), (127,-128), (-1,1) -> Acc_out=5329 with Done on the 4th ACCUM only; In_ready=0 between accept and ACCUM.
- Stale-Finish check: hold Mult_finish=1 from the previous op for 3 cycles after Mult_start -> no accumulate until Finish falls then rises; result counted exactly once.
- Clear asserted in WAIT after the 2nd of 4 terms -> Acc_out=0 next cycle, DRAIN discards the in-flight product, In_ready returns only after Finish rises; the next 4 pairs give a fresh correct sum.
- ACC_W=16, 4 x (-128,-128) = 65536 total -> without DOTP_SATURATE_EN: Acc_out=0, Overflow=1. With DOTP_SATURATE_EN: Acc_out=32767, Overflow=1.
- Resetn low during WAIT -> next cycle all outputs 0, state IDLE, In_ready=1 once Resetn=1; no Done pulse.
